// File: rtl/pipe_reg_chain_pkg.sv
// Shared constants for the elastic register pipeline: legal depth range and
// the width of the occupancy counter.
package pipe_reg_chain_pkg;

    localparam int DEPTH_MIN = 1;
    localparam int DEPTH_MAX = 16;

    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_reg_chain_if.sv
// Producer/consumer bundle of the register pipeline. master is the side that
// supplies words and consumes the output; slave is the pipeline itself.
interface pipe_reg_chain_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    import pipe_reg_chain_pkg::*;

    logic                      in_valid;
    logic [WIDTH-1:0]          in_data;
    logic                      in_ready;
    logic                      out_valid;
    logic [WIDTH-1:0]          out_data;
    logic [WIDTH-1:0]          out_data_n;
    logic                      out_ready;
    logic [occ_w(DEPTH)-1:0]   occupancy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_data_n, occupancy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_data_n, occupancy
    );

endinterface

// File: rtl/pipe_reg_chain_stage.sv
// One pipeline stage: data register plus valid flag. The stage can load
// whenever it is empty or its downstream neighbour is taking its word.
module pipe_reg_stage #(
    parameter int               WIDTH      = 8,
    parameter int               CLEAR_DATA = 0,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             dn_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             rdy
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             w_clr;

    assign w_clr = reset || flush;
    assign rdy   = !r_valid || dn_ready;
    assign valid = r_valid;
    assign data  = r_data;

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_valid <= 1'b0;
        end else if (rdy) begin
            r_valid <= up_valid;
        end
    end

    // Bubbles pass through without disturbing the held data word.
    always_ff @(posedge clk) begin
        if (w_clr) begin
            if (CLEAR_DATA != 0) begin
                r_data <= RESET_VAL;
            end
        end else if (rdy && up_valid) begin
            r_data <= up_data;
        end
    end

endmodule

// File: rtl/pipe_reg_chain.sv
// WIDTH x DEPTH elastic register pipeline with backward-propagating stalls,
// bubble collapse, synchronous flush and a registered occupancy count.
module pipe_reg_chain
    import pipe_reg_chain_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter int               DEPTH      = 4,
    parameter int               CLEAR_DATA = 0,
    parameter logic [WIDTH-1:0] RESET_VAL  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    pipe_reg_chain_if.slave  bus
);

    localparam int OCC_W = occ_w(DEPTH);

    if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_bad_depth
        $error("pipe_reg_chain: DEPTH out of range");
    end

    logic [DEPTH-1:0] w_valid;
    logic [WIDTH-1:0] w_data [DEPTH];
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic [OCC_W-1:0] r_occ;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             w_rdy;
        logic             w_dn_rdy;
        logic             w_up_valid;
        logic [WIDTH-1:0] w_up_data;

        if (i == 0) begin : g_head
            assign w_up_valid = bus.in_valid;
            assign w_up_data  = bus.in_data;
        end else begin : g_body
            assign w_up_valid = w_valid[i-1];
            assign w_up_data  = w_data[i-1];
        end

        // Each stage's ready term lives in its own block so the backward
        // chain is a plain combinational path, not a self-referencing vector.
        if (i == DEPTH - 1) begin : g_tail
            assign w_dn_rdy = bus.out_ready;
        end else begin : g_link
            assign w_dn_rdy = g_stage[i+1].w_rdy;
        end

        pipe_reg_stage #(
            .WIDTH      (WIDTH),
            .CLEAR_DATA (CLEAR_DATA),
            .RESET_VAL  (RESET_VAL)
        ) u_stage (
            .clk      (clk),
            .reset    (reset),
            .flush    (flush),
            .up_valid (w_up_valid),
            .up_data  (w_up_data),
            .dn_ready (w_dn_rdy),
            .valid    (w_valid[i]),
            .data     (w_data[i]),
            .rdy      (w_rdy)
        );
    end

    assign bus.in_ready   = g_stage[0].w_rdy && !flush;
    assign bus.out_valid  = w_valid[DEPTH-1];
    assign bus.out_data   = w_data[DEPTH-1];
    assign bus.out_data_n = ~w_data[DEPTH-1];
    assign bus.occupancy  = r_occ;

    assign w_in_xfer  = bus.in_valid && bus.in_ready;
    assign w_out_xfer = bus.out_valid && bus.out_ready;

    // Tracks popcount of the valid flags without an adder tree.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_occ <= '0;
        end else if (w_in_xfer && !w_out_xfer) begin
            r_occ <= r_occ + OCC_W'(1);
        end else if (!w_in_xfer && w_out_xfer) begin
            r_occ <= r_occ - OCC_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Scoreboard bench for pipe_reg_chain: two instances share stimulus, one
// clearing data on reset/flush and one leaving data untouched.
module tb_pipe_reg_chain;

    logic clk;
    logic reset;
    logic flush;

    int n_chk = 0;
    int n_err = 0;
    logic [7:0] exp_q [$];

    pipe_reg_chain_if #(.WIDTH(8), .DEPTH(4)) bus ();
    pipe_reg_chain_if #(.WIDTH(8), .DEPTH(4)) bus_nc ();

    assign bus_nc.in_valid  = bus.in_valid;
    assign bus_nc.in_data   = bus.in_data;
    assign bus_nc.out_ready = bus.out_ready;

    pipe_reg_chain #(
        .WIDTH(8), .DEPTH(4), .CLEAR_DATA(1), .RESET_VAL(8'hA5)
    ) u_dut (
        .clk(clk), .reset(reset), .flush(flush), .bus(bus)
    );

    pipe_reg_chain #(
        .WIDTH(8), .DEPTH(4), .CLEAR_DATA(0), .RESET_VAL(8'hA5)
    ) u_dut_nc (
        .clk(clk), .reset(reset), .flush(flush), .bus(bus_nc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: sample handshakes before the edge, update the model.
    task automatic tick(output bit acc);
        bit         ix;
        bit         ox;
        logic [7:0] e;
        logic [7:0] en;
        #2;
        ix = (bus.in_valid === 1'b1) && (bus.in_ready === 1'b1);
        ox = (bus.out_valid === 1'b1) && (bus.out_ready === 1'b1);
        if (!reset) begin
            chk("occupancy", 32'(bus.occupancy), 32'(exp_q.size()));
            if (ox) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out_valid", 32'(bus.out_valid), 32'd0);
                end else begin
                    e  = exp_q.pop_front();
                    en = ~e;
                    chk("out_data", 32'(bus.out_data), 32'(e));
                    chk("out_data_n", 32'(bus.out_data_n), 32'(en));
                end
            end
            if (ix) exp_q.push_back(bus.in_data);
        end
        acc = ix;
        @(posedge clk);
        if (reset || flush) exp_q.delete();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit         acc;
        int         idx;
        int         first_a;
        int         first_v;
        int         last_v;
        logic [7:0] keep;

        reset         = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) tick(acc);
        reset = 1'b0;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_occupancy", 32'(bus.occupancy), 32'd0);
        chk("rst_out_data", 32'(bus.out_data), 32'hA5);
        chk("rst_out_data_n", 32'(bus.out_data_n), 32'h5A);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Streaming at full rate.
        bus.out_ready = 1'b1;
        idx = 0; first_a = -1; first_v = -1; last_v = -1;
        for (int t = 0; t < 20; t++) begin
            bus.in_valid = (idx < 8);
            bus.in_data  = 8'(idx + 1);
            if (bus.out_valid === 1'b1) begin
                if (first_v < 0) first_v = t;
                last_v = t;
            end
            if (t == 6) chk("occ_steady", 32'(bus.occupancy), 32'd4);
            tick(acc);
            if (acc) begin
                if (first_a < 0) first_a = t;
                idx++;
            end
        end
        chk("stream_latency", 32'(first_v - first_a), 32'd4);
        chk("stream_back_to_back", 32'(last_v - first_v), 32'd7);
        chk("stream_drained", 32'(exp_q.size()), 32'd0);

        // Stall fill, then simultaneous pop/push.
        bus.out_ready = 1'b0;
        idx = 0;
        for (int t = 0; t < 6; t++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(8'h10 + idx);
            if (t == 4) chk("in_ready_full", 32'(bus.in_ready), 32'd0);
            tick(acc);
            if (acc) idx++;
        end
        chk("stall_accepted", 32'(idx), 32'd4);
        chk("stall_occ", 32'(bus.occupancy), 32'd4);
        bus.out_ready = 1'b1;
        #1;
        chk("in_ready_pop_push", 32'(bus.in_ready), 32'd1);
        for (int t = 0; t < 30; t++) begin
            if (idx == 6 && exp_q.size() == 0) break;
            bus.in_valid = (idx < 6);
            bus.in_data  = 8'(8'h10 + idx);
            tick(acc);
            if (acc) idx++;
            if (t == 0) chk("occ_pop_push", 32'(bus.occupancy), 32'd4);
        end
        chk("stall_all_pushed", 32'(idx), 32'd6);
        chk("stall_drained", 32'(exp_q.size()), 32'd0);

        // Bubble collapse.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h20;
        tick(acc);
        bus.in_valid  = 1'b0;
        for (int k = 0; k < 3; k++) tick(acc);
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h21;
        tick(acc);
        bus.in_valid  = 1'b0;
        for (int k = 0; k < 3; k++) tick(acc);
        chk("collapse_occ", 32'(bus.occupancy), 32'd2);
        chk("collapse_head", 32'(bus.out_data), 32'h20);
        bus.out_ready = 1'b1;
        chk("collapse_drain0", 32'(bus.out_valid), 32'd1);
        tick(acc);
        chk("collapse_drain1", 32'(bus.out_valid), 32'd1);
        tick(acc);
        chk("collapse_empty", 32'(bus.out_valid), 32'd0);

        // Flush with a word offered.
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(8'h30 + k);
            tick(acc);
        end
        flush        = 1'b1;
        bus.in_data  = 8'h33;
        #1;
        chk("flush_in_ready", 32'(bus.in_ready), 32'd0);
        tick(acc);
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_occ", 32'(bus.occupancy), 32'd0);
        chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) tick(acc);

        // Reset together with flush mid-stream.
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'(8'h40 + k);
            tick(acc);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) tick(acc);
        chk("pre_reset_occ", 32'(bus.occupancy), 32'd3);
        keep = (exp_q.size() > 0) ? exp_q[0] : 8'h00;
        chk("pre_reset_head", 32'(keep), 32'h40);
        reset        = 1'b1;
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        tick(acc);
        reset        = 1'b0;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        chk("rf_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rf_occ", 32'(bus.occupancy), 32'd0);
        chk("rf_clear_data", 32'(bus.out_data), 32'hA5);
        chk("rf_nc_out_valid", 32'(bus_nc.out_valid), 32'd0);
        chk("rf_nc_occ", 32'(bus_nc.occupancy), 32'd0);
        chk("rf_nc_keep_data", 32'(bus_nc.out_data), 32'(keep));
        chk("rf_in_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b1;
        for (int k = 0; k < 4; k++) tick(acc);
        chk("final_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
